// File: rtl/crc8_frame_encoder.sv
// ---------------------------------------------------------------------------
// crc8_frame_encoder
//
// Bit-serial CRC-8 encoder that builds the 16-bit frame word for the symbol
// serializer. One payload byte is taken per frame over a valid/ready
// handshake, its CRC-8 is computed MSB first at one bit per clock, and the
// finished {crc, byte} word is staged until the transmit counters wrap to
// symbol 0. Only then is it swapped onto CRC_code, so a frame in flight is
// never torn.
//
// Ports:
//   clk_sys     in   1   system clock (same clock that drives clk_trans)
//   rst_n       in   1   asynchronous active-low reset
//   data_in     in   8   payload byte
//   data_valid  in   1   data_in is valid
//   data_ready  out  1   a byte can be accepted this cycle (combinational)
//   phase       in   8   phase counter from clk_trans
//   sign_cnt    in   4   symbol counter from clk_trans
//   CRC_code    out 16   frame word, bit k goes out in symbol k
//   code_valid  out  1   CRC_code carries a real frame (0 = idle frame)
//   busy        out  1   CRC calculation in progress
//
// Parameters:
//   POLY  CRC-8 generator polynomial without the implicit x^8 term
//   INIT  CRC register value loaded at the start of each byte
// ---------------------------------------------------------------------------
module crc8_frame_encoder #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [7:0]  phase,
  input  logic [3:0]  sign_cnt,
  output logic [15:0] CRC_code,
  output logic        code_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  data_byte;
  logic [7:0]  crc;
  logic [7:0]  crc_next;
  logic        crc_fb;
  logic [2:0]  bit_idx;
  logic        pend;
  logic [15:0] pend_word;

  logic        fb_edge;
  logic        accept;
  logic        calc_done;

  // The frame boundary is the clock on which clk_trans wraps back to symbol 0.
  assign fb_edge    = (phase == 8'hFF) && (sign_cnt == 4'hF);

  // A byte is only taken when nothing is being computed and nothing is
  // staged, which limits throughput to one byte per frame.
  assign data_ready = (state == IDLE) && !pend;
  assign accept     = data_valid && data_ready;
  assign calc_done  = (state == CALC) && (bit_idx == 3'd0);

  // One CRC step for the data bit currently selected by bit_idx. The byte is
  // walked MSB first; no reflection and no final XOR are applied.
  always_comb begin
    crc_fb   = crc[7] ^ data_byte[bit_idx];
    crc_next = {crc[6:0], 1'b0} ^ (crc_fb ? POLY : 8'h00);
  end

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. WAIT can only leave on a boundary that actually
  // unloads the staged word, which keeps the single pending slot safe.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (bit_idx == 3'd0) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (fb_edge && pend) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte latch and serial CRC register. bit_idx counts down 7..0 so that the
  // eighth CALC clock is the one where it reads zero.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      data_byte <= 8'h00;
      crc       <= 8'h00;
      bit_idx   <= 3'd0;
    end else if (accept) begin
      data_byte <= data_in;
      crc       <= INIT;
      bit_idx   <= 3'd7;
    end else if (state == CALC) begin
      crc       <= crc_next;
      bit_idx   <= bit_idx - 3'd1;
    end
  end

  // Pending word. The finished word is captured from crc_next on the last
  // CALC clock, so it only becomes visible to the boundary logic on the
  // following edge; a boundary landing on that same clock emits idle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_word <= 16'h0000;
    end else if (calc_done) begin
      pend      <= 1'b1;
      pend_word <= {crc_next, data_byte};
    end else if (fb_edge && pend) begin
      pend      <= 1'b0;
    end
  end

  // Registered outputs. CRC_code and code_valid only move on the frame
  // boundary, so they stay constant for the whole of a transmitted frame.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      CRC_code   <= 16'h0000;
      code_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_next == CALC);
      if (fb_edge) begin
        if (pend) begin
          CRC_code   <= pend_word;
          code_valid <= 1'b1;
        end else begin
          CRC_code   <= 16'h0000;
          code_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc8_frame_encoder.sv
// ---------------------------------------------------------------------------
// tb_crc8_frame_encoder
//
// Directed self-checking bench for crc8_frame_encoder. The bench owns the
// {sign_cnt, phase} transmit counter, advancing it once per clock and
// jumping it close to the frame boundary where a full 4096-clock frame is
// not needed.
// ---------------------------------------------------------------------------
module tb_crc8_frame_encoder;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [7:0]  phase = 8'h00;
  logic [3:0]  sign_cnt = 4'h0;
  logic [15:0] CRC_code;
  logic        code_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ready_seen = 0;

  crc8_frame_encoder #(
    .POLY(8'h07),
    .INIT(8'h00)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .phase     (phase),
    .sign_cnt  (sign_cnt),
    .CRC_code  (CRC_code),
    .code_valid(code_valid),
    .busy      (busy)
  );

  // 100 MHz system clock.
  always #5 clk_sys = ~clk_sys;

  // Compare one observed value against its expected value and log misses.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference CRC-8 by long division of {byte, 8'h00} by x^8+x^2+x+1.
  function automatic logic [7:0] refCrc(input logic [7:0] b);
    logic [15:0] rem;
    rem = {b, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (rem[i]) begin
        rem = rem ^ (16'h0107 << (i - 8));
      end
    end
    return rem[7:0];
  endfunction

  // Advance one clock: inputs change 1 ns after the edge, and the counter
  // then holds the value the DUT will see on the next edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
    {sign_cnt, phase} = {sign_cnt, phase} + 12'd1;
  endtask

  task automatic setPos(input logic [3:0] s, input logic [7:0] p);
    sign_cnt = s;
    phase    = p;
  endtask

  // Run until the clock that carries the boundary has passed. Also records
  // whether data_ready was seen high before any of those edges.
  task automatic runToBoundary();
    logic was_edge;
    bit   done;
    done = 1'b0;
    for (int n = 0; n < 5000 && !done; n++) begin
      if (data_ready === 1'b1) ready_seen++;
      was_edge = ({sign_cnt, phase} == 12'hFFF);
      step();
      if (was_edge) done = 1'b1;
    end
    if (!done) checkOutput("boundary_timeout", 16'd0, 16'd1);
  endtask

  // Offer a byte and hold it until the DUT takes it (bounded).
  task automatic applyStimulus(input logic [7:0] b);
    logic acc;
    bit   taken;
    taken      = 1'b0;
    data_in    = b;
    data_valid = 1'b1;
    for (int n = 0; n < 20 && !taken; n++) begin
      acc = data_ready;
      step();
      if (acc === 1'b1) taken = 1'b1;
    end
    data_valid = 1'b0;
    if (!taken) checkOutput("accept_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    int bad_crc;
    int bad_valid;
    int bad_ready;
    int busy_cycles;
    logic [7:0] b;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_crc_code",   CRC_code, 16'h0000);
    checkOutput("rst_code_valid", {15'd0, code_valid}, 16'd0);
    checkOutput("rst_busy",       {15'd0, busy}, 16'd0);
    checkOutput("rst_data_ready", {15'd0, data_ready}, 16'd1);
    step();
    step();
    rst_n = 1'b1;
    setPos(4'h0, 8'h00);

    // Two idle frames: output must stay idle and the block ready.
    $display("[TB] idle frames");
    bad_crc = 0; bad_valid = 0; bad_ready = 0;
    for (int n = 0; n < 8192; n++) begin
      step();
      if (CRC_code !== 16'h0000) bad_crc++;
      if (code_valid !== 1'b0) bad_valid++;
      if (data_ready !== 1'b1) bad_ready++;
    end
    checkOutput("idle_crc_nonzero",  bad_crc[15:0], 16'd0);
    checkOutput("idle_valid_set",    bad_valid[15:0], 16'd0);
    checkOutput("idle_ready_low",    bad_ready[15:0], 16'd0);

    // Byte 8'h01 accepted mid-frame.
    $display("[TB] byte 01");
    setPos(4'h0, 8'd10);
    applyStimulus(8'h01);
    busy_cycles = 0;
    for (int n = 0; n < 20 && busy === 1'b1; n++) begin
      busy_cycles++;
      step();
    end
    checkOutput("b01_busy_cycles", busy_cycles[15:0], 16'd8);
    checkOutput("b01_ready_wait",  {15'd0, data_ready}, 16'd0);
    checkOutput("b01_midframe",    {15'd0, code_valid}, 16'd0);
    runToBoundary();
    checkOutput("b01_frame",       CRC_code, 16'h0701);
    checkOutput("b01_valid",       {15'd0, code_valid}, 16'd1);
    checkOutput("b01_ready_after", {15'd0, data_ready}, 16'd1);
    runToBoundary();
    checkOutput("b01_next_idle",   CRC_code, 16'h0000);
    checkOutput("b01_next_valid",  {15'd0, code_valid}, 16'd0);

    // FF then 80 in consecutive frames, with 80 held during WAIT.
    $display("[TB] bytes FF, 80");
    applyStimulus(8'hFF);
    data_in    = 8'h80;
    data_valid = 1'b1;
    ready_seen = 0;
    runToBoundary();
    checkOutput("wait_ready_seen", ready_seen[15:0], 16'd0);
    checkOutput("ff_frame",        CRC_code, 16'hF3FF);
    checkOutput("ff_valid",        {15'd0, code_valid}, 16'd1);
    applyStimulus(8'h80);
    runToBoundary();
    checkOutput("b80_frame",       CRC_code, 16'h8980);
    checkOutput("b80_valid",       {15'd0, code_valid}, 16'd1);

    // CALC completes on the very boundary edge: idle first, word next frame.
    $display("[TB] calc ends on boundary");
    setPos(4'hF, 8'd247);
    applyStimulus(8'h80);
    for (int n = 0; n < 7; n++) step();
    checkOutput("late_pos", {4'd0, sign_cnt, phase}, 16'h0FFF);
    step();
    checkOutput("late_idle_frame", CRC_code, 16'h0000);
    checkOutput("late_idle_valid", {15'd0, code_valid}, 16'd0);
    checkOutput("late_busy",       {15'd0, busy}, 16'd0);
    runToBoundary();
    checkOutput("late_frame",      CRC_code, 16'h8980);
    checkOutput("late_valid",      {15'd0, code_valid}, 16'd1);

    // Reset during CALC.
    $display("[TB] reset during calc");
    setPos(4'h1, 8'h00);
    applyStimulus(8'h55);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rc_crc_code",   CRC_code, 16'h0000);
    checkOutput("rc_code_valid", {15'd0, code_valid}, 16'd0);
    checkOutput("rc_busy",       {15'd0, busy}, 16'd0);
    checkOutput("rc_data_ready", {15'd0, data_ready}, 16'd1);
    step();
    rst_n = 1'b1;
    runToBoundary();
    checkOutput("rc_after_frame", CRC_code, 16'h0000);
    checkOutput("rc_after_valid", {15'd0, code_valid}, 16'd0);

    // Reset while a word is pending.
    $display("[TB] reset while pending");
    setPos(4'h1, 8'h00);
    applyStimulus(8'h31);
    for (int n = 0; n < 10; n++) step();
    checkOutput("rp_ready_low",  {15'd0, data_ready}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rp_crc_code",   CRC_code, 16'h0000);
    checkOutput("rp_code_valid", {15'd0, code_valid}, 16'd0);
    checkOutput("rp_data_ready", {15'd0, data_ready}, 16'd1);
    step();
    rst_n = 1'b1;
    runToBoundary();
    checkOutput("rp_after_frame", CRC_code, 16'h0000);
    checkOutput("rp_after_valid", {15'd0, code_valid}, 16'd0);

    // Sweep all byte values against the reference model.
    $display("[TB] byte sweep");
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      setPos(4'hF, 8'hF0);
      applyStimulus(b);
      runToBoundary();
      checkOutput("sweep_frame", CRC_code, {refCrc(b), b});
      if (b == 8'h00) checkOutput("spot_00", CRC_code, 16'h0000);
      if (b == 8'h31) checkOutput("spot_31", CRC_code, 16'h9731);
    end
    checkOutput("sweep_valid", {15'd0, code_valid}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc8_frame_encoder.md
# crc8_frame_encoder

Bit-serial CRC-8 encoder that builds the 16-bit frame consumed by the symbol serializer (`write_bit`) in the CRC/4FSK transmit path. It accepts one data byte per frame over a valid/ready handshake and computes its CRC-8 one bit per clock. It stages the result and swaps it onto `CRC_code` only at the frame boundary signalled by the shared `phase`/`sign_cnt` counters, so a frame is never torn mid-transmission.

## Interface
- `POLY`, 8'h07: CRC-8 generator polynomial, implicit x^8 term.
- `INIT`, 8'h00: CRC register value loaded at the start of each byte.
- `clk_sys`  in  1: system clock, the same clock that drives `clk_trans`.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `data_in`  in  8: payload byte.
- `data_valid`  in  1: `data_in` is valid.
- `data_ready`  out  1: the block can accept a byte this cycle.
- `phase`  in  8: phase counter from `clk_trans`.
- `sign_cnt`  in  4: symbol counter from `clk_trans`.
- `CRC_code`  out  16: frame word; bit k is transmitted in symbol k.
- `code_valid`  out  1: the current `CRC_code` carries a real frame (0 means an idle frame).
- `busy`  out  1: CRC calculation is in progress.

## Operation
- Frame layout:
  - `CRC_code[7:0]` = data byte, bit 0 sent first.
  - `CRC_code[15:8]` = CRC-8 of the byte.
- CRC update per bit:
  - Bits are processed MSB first (data bit 7 down to 0).
  - fb = crc[7] ^ d; crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
  - No reflection, no final XOR.
- States:
  - IDLE
    - `data_ready`=1 when no word is pending.
    - On `data_valid && data_ready`: latch byte, set crc=INIT, bit index=7, go to CALC.
  - CALC
    - One bit per clock for exactly 8 clocks; `busy`=1; `data_ready`=0.
    - After the 8th bit: write {crc, byte} into the pending register, set `pend`=1, go to WAIT.
  - WAIT
    - Holds while `pend`=1; `data_ready`=0.
    - Returns to IDLE on the clock where the pending word is loaded.
- Frame boundary (`fb_edge`): `phase==255 && sign_cnt==15`, i.e. the edge on which `clk_trans` wraps to symbol 0.
- On `fb_edge`:
  - If `pend`: `CRC_code`<=pending word, `code_valid`<=1, `pend`<=0.
  - Otherwise: `CRC_code`<=16'h0000, `code_valid`<=0.
- Between boundaries, `CRC_code` and `code_valid` hold their values; they never change mid-frame.
- Only one word may be pending. Bytes are not accepted while `pend`=1 or the state is CALC, giving a maximum throughput of one byte per frame (4096 clocks).
- Boundary cases:
  - `fb_edge` during CALC: the word is not yet pending, so an idle frame is emitted and the word goes out at the next boundary.
  - `fb_edge` on the same edge CALC completes: not loaded; `pend` is set and the word loads at the next boundary.
  - `data_valid` held high while `data_ready`=0: ignored, no byte is lost from the block's side; the producer must hold the byte.
  - Reset mid-calculation or while pending: the byte is discarded and all state clears.

## Timing
- Reset values:
  - `CRC_code`=16'h0000, `code_valid`=0, `busy`=0.
  - `data_ready`=1, state=IDLE, `pend`=0.
- Outputs are registered, except `data_ready`, which is decoded combinationally from state and `pend`.
- Latency:
  - Accept edge T; `busy`=1 during cycles T+1..T+8.
  - `pend`=1 from T+8.
  - The word appears on `CRC_code` after the first `fb_edge` at or after T+9.
- `CRC_code` updates on the `fb_edge` clock, so it is stable when `sign_cnt`=0, `phase`=0.

## Test plan
- Reset, then idle for 2 frames → `CRC_code`=16'h0000, `code_valid`=0 throughout, `data_ready`=1.
- Send byte 8'h01 at `phase`=10, `sign_cnt`=0 → `busy` high for 8 cycles; at the next boundary `CRC_code`=16'h0701, `code_valid`=1; the following frame is idle (16'h0000).
- Send bytes 8'hFF and 8'h80 in consecutive frames → frames 16'hF3FF, then 16'h8980. `data_ready` is low from the accept until the load boundary; a second `data_valid` during WAIT is not accepted.
- Accept 8'h80 such that CALC finishes exactly on `fb_edge` (accept at `phase`=247, `sign_cnt`=15) → the current boundary emits idle; the word is emitted one frame later as 16'h8980.
- Assert `rst_n`=0 during CALC (4th bit) and again while `pend`=1 → all outputs return to reset values immediately (asynchronously); no frame is emitted after release.
- Sweep all 256 bytes against a reference CRC-8 model (POLY=07, INIT=00) → `CRC_code[15:8]` matches; spot-check 8'h00→16'h0000 and 8'h31→16'h9731.
